// File: rtl/tribus_arbiter_if.sv
// ---------------------------------------------------------------------------
// tribus_arbiter_if
// Bundles the signals between the shared-net requesters and the arbiter.
//   master : requester side  (drives req, done, bus_sample)
//   slave  : arbiter side    (drives grant, oe, owner_id, bus_busy,
//                             timeout, contention_err)
// Parameters: N_REQ (requester count), ID_W (owner index width).
// ---------------------------------------------------------------------------
interface tribus_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) ();
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] done;
  logic             bus_sample;
  logic [N_REQ-1:0] grant;
  logic [N_REQ-1:0] oe;
  logic [ID_W-1:0]  owner_id;
  logic             bus_busy;
  logic             timeout;
  logic             contention_err;

  modport master (
    output req, done, bus_sample,
    input  grant, oe, owner_id, bus_busy, timeout, contention_err
  );

  modport slave (
    input  req, done, bus_sample,
    output grant, oe, owner_id, bus_busy, timeout, contention_err
  );
endinterface

// File: rtl/tribus_arbiter.sv
// ---------------------------------------------------------------------------
// tribus_arbiter
// Round-robin owner selection for a shared tri-state net. At most one
// requester holds grant/oe; a dead turnaround gap separates grant from oe,
// and each ownership is bounded by MAX_HOLD cycles of oe.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous, active-high reset
//   bus  - tribus_arbiter_if.slave: req/done/bus_sample in,
//          grant/oe/owner_id/bus_busy/timeout/contention_err out
//
// Parameters: N_REQ (2..16), TURNAROUND (0..7), MAX_HOLD (>=2), ID_W.
//
// Optional build macro CONTENTION_CHECK_EN: when defined, two consecutive
// x/z samples of the shared net while an owner drives it set a sticky
// contention_err. When undefined, contention_err is 0 and bus_sample unused.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | no owner; pick next winner round-robin from rr_ptr
// TURN   | winner granted, oe held low for TURNAROUND cycles
// OWN    | winner drives the net (oe high), hold counter running
// ---------------------------------------------------------------------------
module tribus_arbiter #(
  parameter int N_REQ      = 4,
  parameter int TURNAROUND = 1,
  parameter int MAX_HOLD   = 16,
  parameter int ID_W       = $clog2(N_REQ)
) (
  input logic             clk,
  input logic             rst,
  tribus_arbiter_if.slave bus
);

  localparam int HOLD_W = $clog2(MAX_HOLD);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_TURN = 2'd1,
    S_OWN  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic [N_REQ-1:0]  oe_q, oe_d;
  logic [ID_W-1:0]   owner_q, owner_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [2:0]        turn_cnt_q, turn_cnt_d;
  logic              timeout_q, timeout_d;

  logic              win_found;
  logic [ID_W-1:0]   win_idx;
  int                scan_idx;

  logic req_w, done_w;
  logic hold_limit, turn_last;
  logic own_release, own_exit;
  logic [ID_W-1:0] owner_next_ptr;

  // First set request scanning from rr_ptr upward with wrap.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = 0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_idx = int'(rr_ptr_q) + k;
      if (scan_idx >= N_REQ) scan_idx = scan_idx - N_REQ;
      if (!win_found && bus.req[ID_W'(scan_idx)]) begin
        win_found = 1'b1;
        win_idx   = ID_W'(scan_idx);
      end
    end
  end

  // Requests/releases from anyone but the current owner are ignored here.
  assign req_w          = bus.req[owner_q];
  assign done_w         = bus.done[owner_q];
  assign hold_limit     = (hold_cnt_q == HOLD_W'(MAX_HOLD - 1));
  assign turn_last      = (turn_cnt_q == 3'(TURNAROUND - 1));
  assign own_release    = done_w | ~req_w;
  assign own_exit       = own_release | hold_limit;
  assign owner_next_ptr = (owner_q == ID_W'(N_REQ - 1)) ? '0 : owner_q + ID_W'(1);

  // State register (plus all registered outputs and counters)
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      oe_q       <= '0;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      hold_cnt_q <= '0;
      turn_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      oe_q       <= oe_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      hold_cnt_q <= hold_cnt_d;
      turn_cnt_q <= turn_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (win_found) state_d = (TURNAROUND > 0) ? S_TURN : S_OWN;
      end
      S_TURN: begin
        if (!req_w)         state_d = S_IDLE;
        else if (turn_last) state_d = S_OWN;
      end
      S_OWN: begin
        if (own_exit) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    grant_d    = grant_q;
    oe_d       = oe_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    hold_cnt_d = hold_cnt_q;
    turn_cnt_d = turn_cnt_q;
    timeout_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          grant_d    = N_REQ'(1) << win_idx;
          owner_d    = win_idx;
          turn_cnt_d = '0;
          hold_cnt_d = '0;
          if (TURNAROUND == 0) oe_d = N_REQ'(1) << win_idx;
        end
      end
      S_TURN: begin
        // Abort leaves rr_ptr alone so the same requester keeps priority.
        if (!req_w) begin
          grant_d    = '0;
          turn_cnt_d = '0;
        end else if (turn_last) begin
          oe_d       = grant_q;
          hold_cnt_d = '0;
        end else begin
          turn_cnt_d = turn_cnt_q + 3'd1;
        end
      end
      S_OWN: begin
        if (own_exit) begin
          grant_d    = '0;
          oe_d       = '0;
          rr_ptr_d   = owner_next_ptr;
          hold_cnt_d = '0;
          // A release coinciding with the limit counts as a normal release.
          timeout_d  = ~own_release;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      default: begin
        grant_d = '0;
        oe_d    = '0;
      end
    endcase
  end

  assign bus.grant    = grant_q;
  assign bus.oe       = oe_q;
  assign bus.owner_id = owner_q;
  assign bus.bus_busy = |oe_q;
  assign bus.timeout  = timeout_q;

`ifdef CONTENTION_CHECK_EN
  logic sample_bad;
  logic x_prev_q, x_prev_d;
  logic err_q, err_d;

  // Only a driven net can be in contention; z outside OWN is a normal idle.
  assign sample_bad = (bus.bus_sample === 1'bx) || (bus.bus_sample === 1'bz);

  always_comb begin
    x_prev_d = (state_q == S_OWN) && sample_bad;
    err_d    = err_q | (x_prev_d & x_prev_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_prev_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      x_prev_q <= x_prev_d;
      err_q    <= err_d;
    end
  end

  assign bus.contention_err = err_q;
`else
  logic unused_bus_sample;
  assign unused_bus_sample  = bus.bus_sample;
  assign bus.contention_err = 1'b0;
`endif

endmodule

// File: tb/tb_tribus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_tribus_arbiter
// Directed stimulus against tribus_arbiter (N_REQ=4, TURNAROUND=1,
// MAX_HOLD=16). An ownership model based on owner index and cycles-since-
// grant predicts every output each cycle; literal expectations pin the
// key scenarios (latency, round-robin order, gaps, timeout, abort, reset).
// ---------------------------------------------------------------------------
module tb_tribus_arbiter;
  localparam int N  = 4;
  localparam int TA = 1;
  localparam int MH = 16;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tribus_arbiter_if #(.N_REQ(N), .ID_W(IW)) bus ();

  tribus_arbiter #(
    .N_REQ(N), .TURNAROUND(TA), .MAX_HOLD(MH), .ID_W(IW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Ownership model: m_cur = owner index or -1, m_age = cycles since grant.
  int   m_cur = -1;
  int   m_age = 0;
  int   m_ptr = 0;
  int   m_last = 0;
  bit   m_tmo = 0;
  bit   m_err = 0;
  bit   m_xprev = 0;
  bit   in_own;
  logic [N-1:0] exp_grant, exp_oe;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        m_cur = -1; m_age = 0; m_ptr = 0; m_last = 0;
        m_tmo = 0; m_err = 0; m_xprev = 0;
      end else begin
        m_tmo  = 0;
        in_own = (m_cur >= 0) && (m_age >= TA);
`ifdef CONTENTION_CHECK_EN
        if (in_own && (bus.bus_sample === 1'bx || bus.bus_sample === 1'bz)) begin
          if (m_xprev) m_err = 1;
          m_xprev = 1;
        end else begin
          m_xprev = 0;
        end
`endif
        if (m_cur < 0) begin
          if (bus.req != '0) begin
            for (int k = 0; k < N; k++) begin
              int i;
              i = (m_ptr + k) % N;
              if (bus.req[i]) begin
                m_cur = i;
                break;
              end
            end
            m_last = m_cur;
            m_age  = 0;
          end
        end else if (m_age < TA) begin
          if (!bus.req[m_cur]) m_cur = -1;
          else m_age++;
        end else begin
          if (bus.done[m_cur] || !bus.req[m_cur]) begin
            m_ptr = (m_cur + 1) % N;
            m_cur = -1;
          end else if (m_age - TA == MH - 1) begin
            m_tmo = 1;
            m_ptr = (m_cur + 1) % N;
            m_cur = -1;
          end else begin
            m_age++;
          end
        end
      end
      exp_grant = (m_cur >= 0) ? (N'(1) << m_cur) : '0;
      exp_oe    = (m_cur >= 0 && m_age >= TA) ? (N'(1) << m_cur) : '0;
      check("grant", bus.grant, exp_grant);
      check("oe", bus.oe, exp_oe);
      check("owner_id", bus.owner_id, m_last);
      check("bus_busy", bus.bus_busy, |exp_oe);
      check("timeout", bus.timeout, m_tmo);
      check("contention_err", bus.contention_err, m_err);
      check("oe_onehot", $countones(bus.oe) <= 1, 1);
      check("oe_implies_grant", bus.oe & ~bus.grant, 0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not reach its end, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  logic [N-1:0] prev_grant;
  int order[$];
  int gaps[$];
  int gap_run, oe_run;
  bit seen_oe;
  int first_rise, first_fall, first_tmo, regrant, tmo_cycles, grants_seen;
  int exp_order[5];

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.req = '0;
    bus.done = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bus.req = '0;
    bus.done = '0;
    bus.bus_sample = 1'b1;
    exp_order = '{0, 1, 2, 3, 0};
    repeat (2) @(negedge clk);
    check("reset_grant", bus.grant, 0);
    check("reset_oe", bus.oe, 0);
    check("reset_owner", bus.owner_id, 0);
    rst = 1'b0;

    // Single request: grant one edge later, oe one turnaround later.
    @(negedge clk);
    bus.req = 4'b0001;
    @(posedge clk); #2;
    check("lat_grant", bus.grant, 4'b0001);
    check("lat_oe_low", bus.oe, 4'b0000);
    @(posedge clk); #2;
    check("lat_oe", bus.oe, 4'b0001);
    check("lat_busy", bus.bus_busy, 1);
    check("lat_owner", bus.owner_id, 0);
    @(negedge clk);
    bus.req = '0;
    repeat (2) @(negedge clk);

    // All requesting; each owner releases with done on its 3rd oe cycle.
    do_reset();
    bus.req = 4'b1111;
    prev_grant = '0; gap_run = 0; oe_run = 0; seen_oe = 0;
    for (int c = 0; c < 26; c++) begin
      @(negedge clk);
      if (bus.grant != '0 && prev_grant == '0)
        for (int k = 0; k < N; k++) if (bus.grant[k]) order.push_back(k);
      if (bus.oe != '0) begin
        if (seen_oe && gap_run > 0) gaps.push_back(gap_run);
        gap_run = 0; seen_oe = 1; oe_run++;
      end else begin
        gap_run++; oe_run = 0;
      end
      bus.done = (oe_run == 3) ? bus.oe : '0;
      prev_grant = bus.grant;
    end
    bus.req = '0; bus.done = '0;
    check("rr_count", order.size() >= 5, 1);
    for (int k = 0; k < 5 && k < order.size(); k++)
      check($sformatf("rr_order_%0d", k), order[k], exp_order[k]);
    check("gap_count", gaps.size() >= 4, 1);
    foreach (gaps[k]) check($sformatf("oe_gap_%0d", k), gaps[k], 2);

    // Single holder without done: forced release after MAX_HOLD cycles.
    do_reset();
    bus.req = 4'b0100;
    first_rise = -1; first_fall = -1; first_tmo = -1; regrant = -1;
    tmo_cycles = 0; grants_seen = 0; prev_grant = '0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.oe[2] && first_rise < 0) first_rise = c;
      if (!bus.oe[2] && first_rise >= 0 && first_fall < 0) first_fall = c;
      if (bus.timeout) begin
        tmo_cycles++;
        if (first_tmo < 0) first_tmo = c;
      end
      if (bus.grant[2] && !prev_grant[2]) begin
        grants_seen++;
        if (grants_seen == 2) regrant = c;
      end
      prev_grant = bus.grant;
    end
    bus.req = '0;
    check("hold_len", first_fall - first_rise, 16);
    check("tmo_at_fall", first_tmo, first_fall);
    check("tmo_pulses", tmo_cycles, 2);
    check("regrant_after_idle", regrant - first_tmo, 1);
    repeat (2) @(negedge clk);

    // Abort during turnaround keeps rr_ptr, so requester 1 wins again.
    do_reset();
    bus.req = 4'b0001;
    repeat (2) @(negedge clk);
    bus.req = '0;
    repeat (2) @(negedge clk);
    bus.req = 4'b0010;
    @(posedge clk); #2;
    check("abort_grant", bus.grant, 4'b0010);
    @(negedge clk);
    bus.req = 4'b0001;
    @(posedge clk); #2;
    check("abort_grant_drop", bus.grant, 4'b0000);
    check("abort_no_oe", bus.oe, 4'b0000);
    @(negedge clk);
    bus.req = 4'b0011;
    @(posedge clk); #2;
    check("abort_rewin", bus.grant, 4'b0010);
    @(negedge clk);
    bus.req = '0;
    repeat (2) @(negedge clk);

    // Reset while owning drops everything on the same edge.
    bus.req = 4'b0100;
    repeat (2) @(negedge clk);
    check("pre_rst_oe", bus.oe, 4'b0100);
    rst = 1'b1;
    @(posedge clk); #2;
    check("rst_grant", bus.grant, 0);
    check("rst_oe", bus.oe, 0);
    check("rst_owner", bus.owner_id, 0);
    check("rst_busy", bus.bus_busy, 0);
    @(negedge clk);
    rst = 1'b0;
    bus.req = 4'b1001;
    @(posedge clk); #2;
    check("rst_ptr_zero", bus.grant, 4'b0001);
    @(negedge clk);
    bus.req = '0;
    repeat (2) @(negedge clk);

`ifdef CONTENTION_CHECK_EN
    bus.req = 4'b0001;
    repeat (2) @(negedge clk);
    bus.bus_sample = 1'bx;
    repeat (2) @(negedge clk);
    bus.bus_sample = 1'b1;
    check("cont_set", bus.contention_err, 1);
    bus.req = '0;
    repeat (3) @(negedge clk);
    check("cont_sticky", bus.contention_err, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("cont_cleared", bus.contention_err, 0);
`else
    bus.req = 4'b0001;
    repeat (4) @(negedge clk);
    check("cont_tied_low", bus.contention_err, 0);
    bus.req = '0;
    repeat (2) @(negedge clk);
`endif

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
